// File: rtl/sine_phase_seq.sv
// Phase accumulator sequencer: each frame tick walks every channel through an
// external sine generator and forwards each result downstream, one at a time.
module sine_phase_seq #(
    parameter int NR_CHANNELS   = 4,
    parameter int RADIAN_WIDTH  = 24,
    parameter int CHANNEL_WIDTH = $clog2(NR_CHANNELS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RADIAN_WIDTH-1:0]  s_inc_d,
    input  logic [CHANNEL_WIDTH-1:0] s_inc_ch,
    input  logic                     s_inc_dv,
    output logic                     s_inc_dr,
    input  logic                     s_tick,
    output logic [RADIAN_WIDTH-1:0]  m_rad_d,
    output logic [CHANNEL_WIDTH-1:0] m_rad_ch,
    output logic                     m_rad_dv,
    input  logic                     m_rad_dr,
    input  logic [RADIAN_WIDTH-1:0]  s_sin_d,
    input  logic [CHANNEL_WIDTH-1:0] s_sin_ch,
    input  logic                     s_sin_dv,
    output logic                     s_sin_dr,
    output logic [RADIAN_WIDTH-1:0]  m_out_d,
    output logic [CHANNEL_WIDTH-1:0] m_out_ch,
    output logic                     m_out_dv,
    input  logic                     m_out_dr,
    output logic                     overrun,
    output logic                     ch_err
);

    localparam int PI_INT = $rtoi(2.0 ** (RADIAN_WIDTH - 3) * 3.141592653589793 + 0.5);
    localparam logic [RADIAN_WIDTH-1:0]        PI_U     = RADIAN_WIDTH'(PI_INT);
    localparam logic signed [RADIAN_WIDTH:0]   PI_S     = (RADIAN_WIDTH + 1)'(PI_INT);
    localparam logic [RADIAN_WIDTH-1:0]        TWO_PI_W = RADIAN_WIDTH'(2 * PI_INT);
    localparam logic [CHANNEL_WIDTH-1:0]       LAST_CH  = CHANNEL_WIDTH'(NR_CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t                       state;
    logic [CHANNEL_WIDTH-1:0]     ch;
    logic [CHANNEL_WIDTH-1:0]     next_ch;
    logic [RADIAN_WIDTH-1:0]      acc [NR_CHANNELS];
    logic [RADIAN_WIDTH-1:0]      inc [NR_CHANNELS];
    logic [RADIAN_WIDTH-1:0]      inc_clamped;
    logic [RADIAN_WIDTH-1:0]      acc_next;
    logic signed [RADIAN_WIDTH:0] acc_sum;

    assign s_inc_dr    = ~rst;
    assign next_ch     = ch + CHANNEL_WIDTH'(1);
    assign inc_clamped = (s_inc_d > PI_U) ? PI_U : s_inc_d;

    // One extra bit holds acc+inc; wrapping by 2*PI keeps the phase in [-PI, PI],
    // so the low bits of the modular subtraction are exact.
    always_comb begin
        acc_sum  = {acc[ch][RADIAN_WIDTH-1], acc[ch]} + {1'b0, inc[ch]};
        acc_next = acc_sum[RADIAN_WIDTH-1:0];
        if (acc_sum > PI_S)
            acc_next = acc_sum[RADIAN_WIDTH-1:0] - TWO_PI_W;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ch       <= '0;
            m_rad_d  <= '0;
            m_rad_ch <= '0;
            m_rad_dv <= 1'b0;
            s_sin_dr <= 1'b0;
            m_out_d  <= '0;
            m_out_ch <= '0;
            m_out_dv <= 1'b0;
            overrun  <= 1'b0;
            ch_err   <= 1'b0;
            for (int i = 0; i < NR_CHANNELS; i++) begin
                acc[i] <= '0;
                inc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NR_CHANNELS; i++)
                if (s_inc_dv && s_inc_ch == CHANNEL_WIDTH'(i))
                    inc[i] <= inc_clamped;

            if (s_tick && state != IDLE)
                overrun <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (s_tick) begin
                        state    <= ISSUE;
                        ch       <= '0;
                        m_rad_d  <= acc[0];
                        m_rad_ch <= '0;
                        m_rad_dv <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (m_rad_dr) begin
                        state    <= WAIT;
                        m_rad_dv <= 1'b0;
                        s_sin_dr <= 1'b1;
                    end
                end
                WAIT: begin
                    // Replies for another channel are swallowed; keep waiting for ours.
                    if (s_sin_dv) begin
                        if (s_sin_ch == ch) begin
                            state    <= OUT;
                            s_sin_dr <= 1'b0;
                            m_out_d  <= s_sin_d;
                            m_out_ch <= ch;
                            m_out_dv <= 1'b1;
                            acc[ch]  <= acc_next;
                        end else begin
                            ch_err <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (m_out_dr) begin
                        m_out_dv <= 1'b0;
                        if (ch == LAST_CH) begin
                            state <= IDLE;
                        end else begin
                            state    <= ISSUE;
                            ch       <= next_ch;
                            m_rad_d  <= acc[next_ch];
                            m_rad_ch <= next_ch;
                            m_rad_dv <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sine_phase_seq.sv
// Scoreboard bench for sine_phase_seq: the bench plays the sine generator and
// downstream sink, while two monitors check radians and outputs against queues.
module tb_sine_phase_seq;

    localparam int NR = 4;
    localparam int W  = 24;
    localparam int CW = 2;
    localparam int PI_V = 6588397;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  s_inc_d;
    logic [CW-1:0] s_inc_ch;
    logic          s_inc_dv;
    logic          s_inc_dr;
    logic          s_tick;
    logic [W-1:0]  m_rad_d;
    logic [CW-1:0] m_rad_ch;
    logic          m_rad_dv;
    logic          m_rad_dr;
    logic [W-1:0]  s_sin_d;
    logic [CW-1:0] s_sin_ch;
    logic          s_sin_dv;
    logic          s_sin_dr;
    logic [W-1:0]  m_out_d;
    logic [CW-1:0] m_out_ch;
    logic          m_out_dv;
    logic          m_out_dr;
    logic          overrun;
    logic          ch_err;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [W-1:0]  d;
    } item_t;

    item_t        rad_q[$];
    item_t        out_q[$];
    item_t        rad_e;
    item_t        out_e;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] sin_seq;

    sine_phase_seq dut (
        .clk(clk), .rst(rst),
        .s_inc_d(s_inc_d), .s_inc_ch(s_inc_ch), .s_inc_dv(s_inc_dv), .s_inc_dr(s_inc_dr),
        .s_tick(s_tick),
        .m_rad_d(m_rad_d), .m_rad_ch(m_rad_ch), .m_rad_dv(m_rad_dv), .m_rad_dr(m_rad_dr),
        .s_sin_d(s_sin_d), .s_sin_ch(s_sin_ch), .s_sin_dv(s_sin_dv), .s_sin_dr(s_sin_dr),
        .m_out_d(m_out_d), .m_out_ch(m_out_ch), .m_out_dv(m_out_dv), .m_out_dr(m_out_dr),
        .overrun(overrun), .ch_err(ch_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Radian monitor: a handshake will complete at the coming rising edge.
    always @(negedge clk) begin
        if (!rst && m_rad_dv && m_rad_dr) begin
            if (rad_q.size() == 0) begin
                checkOutput("rad_unexpected", 32'd1, 32'd0);
            end else begin
                rad_e = rad_q.pop_front();
                checkOutput("rad_ch", 32'(m_rad_ch), 32'(rad_e.ch));
                checkOutput("rad_d", 32'(m_rad_d), 32'(rad_e.d));
            end
        end
    end

    // Output monitor: same scheme on the downstream handshake.
    always @(negedge clk) begin
        if (!rst && m_out_dv && m_out_dr) begin
            if (out_q.size() == 0) begin
                checkOutput("out_unexpected", 32'd1, 32'd0);
            end else begin
                out_e = out_q.pop_front();
                checkOutput("out_ch", 32'(m_out_ch), 32'(out_e.ch));
                checkOutput("out_d", 32'(m_out_d), 32'(out_e.d));
            end
        end
    end

    task automatic writeInc(input int ch, input logic [W-1:0] val);
        s_inc_ch = CW'(ch);
        s_inc_d  = val;
        s_inc_dv = 1'b1;
        waitCycle();
        s_inc_dv = 1'b0;
    endtask

    // Serves one channel as generator and sink, with optional disturbances.
    task automatic applyStimulus(input int c, input int stall, input bit bad,
                                 input bit wait_tick, input bit out_tick);
        item_t it;
        int    n = 0;
        while (!m_rad_dv && n < 20) begin
            waitCycle();
            n++;
        end
        checkOutput("rad_dv_wait", 32'(m_rad_dv), 32'd1);
        if (!m_rad_dv)
            return;
        m_rad_dr = 1'b1;
        waitCycle();
        m_rad_dr = 1'b0;
        checkOutput("sin_dr_in_wait", 32'(s_sin_dr), 32'd1);

        if (wait_tick) begin
            checkOutput("overrun_before", 32'(overrun), 32'd0);
            s_tick = 1'b1;
            waitCycle();
            s_tick = 1'b0;
            checkOutput("overrun_set", 32'(overrun), 32'd1);
        end

        if (bad) begin
            s_sin_d  = 24'hBADBAD;
            s_sin_ch = CW'(c + 1);
            s_sin_dv = 1'b1;
            waitCycle();
            s_sin_dv = 1'b0;
            checkOutput("ch_err_set", 32'(ch_err), 32'd1);
            checkOutput("no_out_on_bad", 32'(m_out_dv), 32'd0);
            waitCycle();
            waitCycle();
            checkOutput("still_wait", 32'(s_sin_dr), 32'd1);
            checkOutput("no_out_still", 32'(m_out_dv), 32'd0);
        end

        if (stall > 0)
            m_out_dr = 1'b0;
        sin_seq = sin_seq + 24'd1;
        it.ch = CW'(c);
        it.d  = sin_seq;
        out_q.push_back(it);
        s_sin_d  = sin_seq;
        s_sin_ch = CW'(c);
        s_sin_dv = 1'b1;
        waitCycle();
        s_sin_dv = 1'b0;
        if (out_tick)
            s_tick = 1'b1;

        if (stall > 0) begin
            checkOutput("sin_dr_in_out", 32'(s_sin_dr), 32'd0);
            for (int k = 0; k < stall; k++) begin
                checkOutput("stall_dv", 32'(m_out_dv), 32'd1);
                checkOutput("stall_d", 32'(m_out_d), 32'(sin_seq));
                checkOutput("stall_ch", 32'(m_out_ch), 32'(c));
                checkOutput("stall_no_rad", 32'(m_rad_dv), 32'd0);
                waitCycle();
            end
            m_out_dr = 1'b1;
        end
        waitCycle();
        s_tick = 1'b0;
    endtask

    task automatic runFrame(input int r0, input int r1, input int r2, input int r3,
                            input int stall_ch, input int bad_ch, input int wtick_ch,
                            input bit out_tick);
        int    r[4];
        item_t it;
        r = '{r0, r1, r2, r3};
        checkOutput("idle_before_frame", 32'(m_rad_dv), 32'd0);
        for (int c = 0; c < NR; c++) begin
            it.ch = CW'(c);
            it.d  = W'(r[c]);
            rad_q.push_back(it);
        end
        s_tick = 1'b1;
        waitCycle();
        s_tick = 1'b0;
        checkOutput("rad_dv_after_tick", 32'(m_rad_dv), 32'd1);
        for (int c = 0; c < NR; c++)
            applyStimulus(c, (c == stall_ch) ? 10 : 0, c == bad_ch, c == wtick_ch,
                          out_tick && (c == NR - 1));
        waitCycle();
        checkOutput("idle_after_frame", 32'(m_rad_dv), 32'd0);
        checkOutput("out_q_drained", 32'(out_q.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; s_inc_d = '0; s_inc_ch = '0; s_inc_dv = 1'b0; s_tick = 1'b0;
        m_rad_dr = 1'b0; s_sin_d = '0; s_sin_ch = '0; s_sin_dv = 1'b0; m_out_dr = 1'b1;
        sin_seq = 24'h100000;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rad_dv", 32'(m_rad_dv), 32'd0);
        checkOutput("rst_out_dv", 32'(m_out_dv), 32'd0);
        checkOutput("rst_sin_dr", 32'(s_sin_dr), 32'd0);
        checkOutput("rst_inc_dr", 32'(s_inc_dr), 32'd0);
        checkOutput("rst_flags", {30'd0, overrun, ch_err}, 32'd0);
        checkOutput("rst_data", {m_rad_d, 8'd0} | 32'(m_out_d) | 32'(m_rad_ch) | 32'(m_out_ch), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("inc_dr_after_rst", 32'(s_inc_dr), 32'd1);
        waitCycle();

        writeInc(0, 24'd3294198);
        writeInc(1, 24'hFFFFFF);
        runFrame(0, 0, 0, 0, -1, -1, -1, 1'b0);
        runFrame(3294198, PI_V, 0, 0, -1, -1, 0, 1'b0);
        runFrame(6588396, 0, 0, 0, -1, 1, -1, 1'b0);
        runFrame(-3294200, PI_V, 0, 0, 2, -1, -1, 1'b0);

        // Abort a frame while the first radian is still being offered.
        s_tick = 1'b1;
        waitCycle();
        s_tick = 1'b0;
        checkOutput("issue_dv", 32'(m_rad_dv), 32'd1);
        waitCycle();
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rad_dv", 32'(m_rad_dv), 32'd0);
        checkOutput("rst_clears_flags", {30'd0, overrun, ch_err}, 32'd0);
        waitCycle();
        rst = 1'b0;
        waitCycle();
        checkOutput("no_restart", 32'(m_rad_dv), 32'd0);

        writeInc(0, 24'd100);
        runFrame(0, 0, 0, 0, -1, -1, -1, 1'b0);
        runFrame(100, 0, 0, 0, -1, -1, -1, 1'b1);
        checkOutput("overrun_at_last_out", 32'(overrun), 32'd1);
        waitCycle();
        checkOutput("no_frame_from_late_tick", 32'(m_rad_dv), 32'd0);
        checkOutput("rad_q_drained", 32'(rad_q.size()), 32'd0);
        checkOutput("ch_err_final", 32'(ch_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
